shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit register built from positive-edge D flip-flops.
- N_REQ requesters compete for write access. The block grants one requester at a time, loads that requester's data word into the register, acknowledges it, then releases.
- The register output q is broadcast to all consumers. The block sits between requester logic and the flip-flop register it owns.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register and of each requester's data word.
- PTR_W, $clog2(N_REQ), width of the round-robin pointer and grant index (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester write request; level, held until ack.
- wr_data  input  N_REQ*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot grant; all zeros when no requester is granted.
- ack  output  N_REQ  one-hot, one-cycle pulse when the granted word has been written.
- grant_idx  output  PTR_W  index of the current or last granted requester.
- q  output  WIDTH  shared register contents.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, grant=0, ack=0, grant_idx=0, q=0, busy=0.
  - Round-robin pointer ptr=0.
  - Takes effect immediately, including mid-transaction. Any in-flight write is discarded and q returns to 0.
- FSM states are IDLE, GRANT, WRITE, RELEASE. All outputs come from registers; there are no combinational paths from req to any output.
- IDLE:
  - If req is nonzero, select the first asserted req starting at index ptr and wrapping modulo N_REQ.
  - At the next edge: grant one-hot to the winner, grant_idx=winner, state goes to GRANT.
  - If req is zero, stay in IDLE.
- GRANT:
  - One cycle. This gives the requester one full cycle to see grant before capture.
  - Next state is WRITE.
- WRITE:
  - At the edge leaving WRITE: q <= wr_data slice of grant_idx, and ack[grant_idx] goes high for exactly one cycle.
  - Next state is RELEASE.
- RELEASE:
  - At the edge leaving RELEASE: grant=0, ack=0, ptr=(grant_idx+1) mod N_REQ, state goes to IDLE.
- Timing:
  - Latency: req first seen high in IDLE → q updated 3 edges later; ack is visible in the same cycle as the new q.
  - Throughput: one write per 4 cycles under continuous contention.
- Request and data rules:
  - A requester must drop req in the cycle after it sees ack. If req is still high in IDLE, it is a new request and is arbitrated normally under round-robin.
  - A granted requester dropping req during GRANT or WRITE does not abort the transaction; the write completes with the current wr_data.
  - wr_data is sampled only at the WRITE edge. Changes before that edge are not captured.
  - Requests arriving while busy=1 wait; they are not lost, because req is a level.
- Fairness:
  - ptr advances only after a completed transaction.
  - Each requester waits at most N_REQ-1 transactions.
  - Pointer wrap: N_REQ-1 → 0.
- Invariants:
  - grant and ack are always one-hot or zero.
  - ack is only ever asserted at the bit set in grant.
  - q holds its value in every state except at the WRITE edge.

Decomposition:
- Shared package: the FSM state encoding (IDLE=2'd0, GRANT=2'd1, WRITE=2'd2, RELEASE=2'd3) and a helper function for the ceiling log2 used by PTR_W.
- One natural sub-module: rr_priority_pick. It is combinational: inputs req and ptr; outputs winner index and a valid flag.
- The FSM, grant/ack registers and the q register stay in shared_reg_arbiter. q is the flip-flop bank under control.

Test Plan:
- Reset mid-WRITE: drive req=0001 and wr_data[0]=8'hA5; assert rst_n=0 while state is WRITE. Required: q=0, grant=0, ack=0, busy=0 immediately, with no clock edge needed.
- Single requester:
  - req=0100, wr_data[2]=8'h3C.
  - Required: grant=0100 one edge later, ack=0100 and q=8'h3C three edges later, grant=0 after the next edge.
  - busy is high for 3 cycles.
- Full contention rotation:
  - req=1111 held, each requester dropping req after its ack, then reasserting it. Data words are 8'h10, 8'h11, 8'h12, 8'h13.
  - Required: grants in order 0,1,2,3,0; q sequence 10,11,12,13,10; one ack every 4 cycles.
- Wrap-around: set ptr=3 by completing a transaction for requester 2, then drive req=1001. Required: requester 3 is granted first, then requester 0.
- Late data and dropped req:
  - Grant requester 1 with wr_data=8'h55.
  - Change wr_data to 8'h77 during GRANT and drop req during WRITE.
  - Required: q=8'h77 and ack still pulses for requester 1.
- Held req after ack: requester 0 keeps req=1 after ack while requester 1 also requests. Required: requester 1 is granted next; requester 0 is granted only after that.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter_pkg
// Description : Shared types and helpers for the shared-register arbiter:
//               FSM state encoding and a ceiling-log2 helper for pointer width.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_reg_arbiter_pkg;

  // Transaction sequencer states; encoding is fixed so it can be probed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Ceiling log2, clamped to at least 1 so a pointer always has a bit.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : shared_reg_arbiter_pkg
`default_nettype wire

// File: rtl/shared_reg_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after ptr, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2_f(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_sum  = '0;
    w_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Round-robin arbiter and write sequencer owning one shared
//               WIDTH-bit register. One grant -> write -> ack -> release
//               transaction per four cycles; all outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = clog2_f(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic [PTR_W-1:0]       grant_idx,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_grant_idx;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_ack;
  logic [WIDTH-1:0]   r_q;
  logic               r_busy;

  logic [PTR_W-1:0]   w_winner;
  logic               w_valid;
  logic [WIDTH-1:0]   w_wr_word;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // Select the granted requester's data word for capture at the WRITE edge.
  always_comb begin
    w_wr_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_idx == PTR_W'(i)) begin
        w_wr_word = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Transaction sequencer, register bank and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_idx <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_q         <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant     <= N_REQ'(1) << w_winner;
            r_grant_idx <= w_winner;
            r_busy      <= 1'b1;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Requester gets one full cycle to observe grant before capture.
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_q     <= w_wr_word;
          r_ack   <= r_grant;
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          r_grant <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
          // Pointer moves only on a completed transaction, wrapping at N_REQ-1.
          if (r_grant_idx == PTR_W'(N_REQ - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_grant_idx + PTR_W'(1);
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign grant_idx = r_grant_idx;
  assign q         = r_q;
  assign busy      = r_busy;

endmodule : shared_reg_arbiter
`default_nettype wire
